// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for the pipe_chain register chain.
package pipe_chain_pkg;

    typedef enum logic {
        MODE_STAGED = 1'b0,
        MODE_RIPPLE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_STAGED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RIPPLE = 2'd2
    } state_e;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One chain stage: data register plus valid bit, loading either prev+INC or a direct value.
module pipe_stage #(
    parameter int WIDTH = 3,
    parameter int INC   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             den,
    input  logic             sel_direct,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_prev,
    input  logic [WIDTH-1:0] d_direct,
    output logic             vld,
    output logic [WIDTH-1:0] data
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld  <= 1'b0;
            data <= '0;
        end else begin
            if (en)
                vld <= v_in;
            if (den)
                data <= sel_direct ? d_direct : d_prev + INC_W;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Back-pressured register chain adding INC per stage; staged pipeline or single-cycle ripple.
module pipe_chain
    import pipe_chain_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int DEPTH = 5,
    parameter int INC   = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [DEPTH*WIDTH-1:0]   stage_data,
    output logic [occ_w(DEPTH)-1:0]  occupancy,
    output logic                     active_mode
);

    localparam int OCC_W = occ_w(DEPTH);

    state_e                          state;
    logic [DEPTH-1:0]                vld_pipe;
    logic [DEPTH-1:0][WIDTH-1:0]     stg;
    logic [DEPTH-1:0][WIDTH-1:0]     d_prev;
    logic [DEPTH-1:0][WIDTH-1:0]     d_dir;
    logic [DEPTH-1:0]                v_in;
    logic [DEPTH-1:0]                sel_dir;
    logic                            advance;
    logic                            accept;
    logic                            den;
    logic                            drained;

    // Same stall rule serves both modes: the tail is free or being taken.
    assign advance  = !vld_pipe[DEPTH-1] || out_ready;
    assign in_ready = rstn && advance && (mode == active_mode);
    assign accept   = in_valid && in_ready;
    assign den      = active_mode ? accept : advance;
    assign drained  = (vld_pipe == '0);

    assign out_valid  = vld_pipe[DEPTH-1];
    assign out_data   = stg[DEPTH-1];
    assign stage_data = stg;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        localparam logic [WIDTH-1:0] OFS = WIDTH'(k * INC);

        assign d_dir[k]   = active_mode ? in_data + OFS : in_data;
        assign sel_dir[k] = (k == 0) || active_mode;

        // In ripple mode only the tail valid bit carries the held word.
        if (k == 0) begin : g_head
            assign d_prev[k] = '0;
            assign v_in[k]   = active_mode ? 1'b0 : accept;
        end else if (k == DEPTH-1) begin : g_tail
            assign d_prev[k] = stg[k-1];
            assign v_in[k]   = active_mode ? accept : vld_pipe[k-1];
        end else begin : g_mid
            assign d_prev[k] = stg[k-1];
            assign v_in[k]   = active_mode ? 1'b0 : vld_pipe[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH), .INC(INC)) u_stage (
            .clk        (clk),
            .rstn       (rstn),
            .en         (advance),
            .den        (den),
            .sel_direct (sel_dir[k]),
            .v_in       (v_in[k]),
            .d_prev     (d_prev[k]),
            .d_direct   (d_dir[k]),
            .vld        (vld_pipe[k]),
            .data       (stg[k])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++)
            occupancy = occupancy + OCC_W'(vld_pipe[k]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_STAGED;
            active_mode <= MODE_STAGED;
        end else begin
            case (state)
                ST_STAGED, ST_RIPPLE: begin
                    if (mode != active_mode) begin
                        if (drained) begin
                            active_mode <= mode;
                            state       <= mode ? ST_RIPPLE : ST_STAGED;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mode == active_mode) begin
                        state <= active_mode ? ST_RIPPLE : ST_STAGED;
                    end else if (drained) begin
                        active_mode <= mode;
                        state       <= mode ? ST_RIPPLE : ST_STAGED;
                    end
                end
                default: state <= ST_STAGED;
            endcase
        end
    end

endmodule
